alu_rr_arbiter: RTL

- Shares one registered add/sub ALU (2-cycle input-reg/output-reg pipeline, 2-bit op: nop=0, add=1, sub=2) between NREQ requesters.
- Round-robin arbitration issues at most one operation per cycle over a valid/ready handshake.
- A tag pipeline tracks which requester owns each in-flight operation and routes each ALU result back as a one-cycle response pulse.
- Sits between requester blocks and the ALU instance; the ALU itself is untouched.

---
 rtl/alu_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin front end that shares one registered add/sub ALU
// between NREQ requesters and routes each result back to its owner.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/ready  per-requester valid/ready handshake (ready one-hot or zero)
//   req_op/a/b       per-requester payload, slice i of each packed vector
//   rsp_valid/data   one-cycle result pulse and held result per requester
//   alu_op/a/b       winner payload driven to the ALU (nop/0 when idle)
//   alu_in_valid     ALU input strobe, high whenever a grant is issued
//   alu_out/_valid   ALU result and its valid strobe
//   tag_err          sticky flag: tag pipeline and ALU valid disagreed
//
// Optional build macro ALU_ARB_STATS_EN adds:
//   stat_grants      16-bit saturating handshake counter per requester
//   stat_idle        16-bit saturating count of cycles without a grant

module alu_rr_arbiter #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH*NREQ-1:0]   rsp_data,
  output logic [1:0]              alu_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic                    alu_in_valid,
  input  logic [WIDTH-1:0]        alu_out,
  input  logic                    alu_out_valid,
  output logic                    tag_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]      stat_grants,
  output logic [15:0]             stat_idle
`endif
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned OPW  = 2;
  localparam int unsigned LAST = LATENCY - 1;

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] cand;
  logic            found;
  logic            grant;

  logic            tag_vld [LATENCY];
  logic [IDXW-1:0] tag_idx [LATENCY];

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // No grants can be issued while reset is held.
  assign grant = found & ~rst;

  // Grant decode and winner payload mux toward the ALU.
  always_comb begin
    req_ready    = '0;
    alu_op       = 2'b00;
    alu_a        = '0;
    alu_b        = '0;
    alu_in_valid = grant;
    if (grant) begin
      req_ready[winner] = 1'b1;
      alu_op            = req_op[OPW*winner +: OPW];
      alu_a             = req_a[WIDTH*winner +: WIDTH];
      alu_b             = req_b[WIDTH*winner +: WIDTH];
    end
  end

  // Pointer, tag pipeline shadowing the ALU, and registered response routing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDXW'(NREQ - 1);
      for (int unsigned k = 0; k < LATENCY; k++) begin
        tag_vld[k] <= 1'b0;
        tag_idx[k] <= '0;
      end
      rsp_valid <= '0;
      rsp_data  <= '0;
      tag_err   <= 1'b0;
    end else begin
      if (grant) begin
        ptr <= winner;
      end
      tag_vld[0] <= grant;
      tag_idx[0] <= winner;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
      // Responses follow the tags, not the ALU strobe, so a faulty ALU
      // still cannot misroute or drop a response.
      rsp_valid <= '0;
      if (tag_vld[LAST]) begin
        rsp_valid[tag_idx[LAST]]                <= 1'b1;
        rsp_data[WIDTH*tag_idx[LAST] +: WIDTH] <= alu_out;
      end
      if (tag_vld[LAST] != alu_out_valid) begin
        tag_err <= 1'b1;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester grant counters and idle-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_idle   <= '0;
    end else begin
      if (grant) begin
        if (stat_grants[16*winner +: 16] != 16'hFFFF) begin
          stat_grants[16*winner +: 16] <= stat_grants[16*winner +: 16] + 16'd1;
        end
      end else if (stat_idle != 16'hFFFF) begin
        stat_idle <= stat_idle + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule
